// File: rtl/cmem_nway.sv
// rtl/cmem_nway.sv - N-way set-associative line cache with multi-port reads, write-allocate stores and invalidate
module cmem_nway #(
    parameter int WAYS   = 4,
    parameter int SETS   = 64,
    parameter int LINE_W = 512,
    parameter int NRD    = 2,
    parameter int ADDR_W = 64,
    localparam int LB    = LINE_W / 8,
    localparam int OFF_W = $clog2(LB),
    localparam int BLK_W = ADDR_W - OFF_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NRD-1:0]         rd_req,
    input  logic [NRD*BLK_W-1:0]   rd_addr,
    output logic [LINE_W-1:0]      rd_data,
    output logic [NRD-1:0]         rd_dv,
    input  logic                   wr_req,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [63:0]            wr_data,
    input  logic [1:0]             wr_len,
    output logic                   wr_ack,
    input  logic                   inv_req,
    input  logic [BLK_W-1:0]       inv_addr,
    output logic                   inv_ack,
    output logic                   ext_rd,
    output logic [BLK_W-1:0]       ext_addr,
    input  logic [LINE_W-1:0]      ext_data,
    input  logic                   ext_dv
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = BLK_W - IDX_W;
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PW    = (NRD > 1) ? $clog2(NRD) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;
    localparam logic [2:0] S_INVAL  = 3'd6;

    localparam logic [1:0] OP_RD  = 2'd0;
    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_INV = 2'd2;

    logic [2:0]        state;
    logic [1:0]        op_q;
    logic [BLK_W-1:0]  blk_q;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        len_q;
    logic [63:0]       wdat_q;
    logic [PW-1:0]     port_q;
    logic [PW-1:0]     rr_port;
    logic [WW-1:0]     way_q;
    logic              hit_q;
    logic [LINE_W-1:0] line_q;

    logic [LINE_W-1:0] data_mem [WAYS][SETS];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic              vld      [WAYS][SETS];
    logic [WW-1:0]     vic_ptr  [SETS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;

    assign idx = blk_q[IDX_W-1:0];
    assign tag = blk_q[BLK_W-1:IDX_W];

    // Round-robin read-port pick, scanning from the port after the last grant
    logic              rd_any;
    logic [PW-1:0]     rd_gnt;
    logic [BLK_W-1:0]  rd_blk;
    always_comb begin
        rd_any = 1'b0;
        rd_gnt = '0;
        rd_blk = '0;
        for (int i = 0; i < NRD; i++) begin
            int j;
            j = (int'(rr_port) + i) % NRD;
            if (!rd_any && rd_req[j]) begin
                rd_any = 1'b1;
                rd_gnt = PW'(j);
                rd_blk = rd_addr[j*BLK_W +: BLK_W];
            end
        end
    end

    // Tag match across all ways of the indexed set
    logic          hit;
    logic [WW-1:0] hit_way;
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && vld[w][idx] && tag_mem[w][idx] == tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // Victim: lowest invalid way, otherwise the set's rotating pointer
    logic          vic_found;
    logic [WW-1:0] vic_way;
    logic [WW-1:0] vic_next;
    always_comb begin
        vic_found = 1'b0;
        vic_way   = vic_ptr[idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_found && !vld[w][idx]) begin
                vic_found = 1'b1;
                vic_way   = WW'(w);
            end
        end
        vic_next = (vic_ptr[idx] == WW'(WAYS - 1)) ? '0 : vic_ptr[idx] + 1'b1;
    end

    // Store address offset forced to the natural alignment of the access size
    logic [OFF_W-1:0] wr_off;
    assign wr_off = wr_addr[OFF_W-1:0] & ~OFF_W'((4'd1 << wr_len) - 4'd1);

    // Byte-merge of the latched store data into the target line
    logic [7:0]        bmask8;
    logic [LB-1:0]     bmask;
    logic [LINE_W-1:0] wmask;
    logic [LINE_W-1:0] wline;
    logic [LINE_W-1:0] merged;
    always_comb begin
        case (len_q)
            2'd0:    bmask8 = 8'h01;
            2'd1:    bmask8 = 8'h03;
            2'd2:    bmask8 = 8'h0F;
            default: bmask8 = 8'hFF;
        endcase
        bmask = LB'(bmask8) << off_q;
        wline = LINE_W'(wdat_q) << {off_q, 3'b000};
        for (int k = 0; k < LB; k++) begin
            wmask[8*k +: 8] = {8{bmask[k]}};
        end
        merged = (data_mem[way_q][idx] & ~wmask) | (wline & wmask);
    end

    // Control FSM: arbitration, lookup, miss handling and state bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_q    <= OP_RD;
            blk_q   <= '0;
            off_q   <= '0;
            len_q   <= '0;
            wdat_q  <= '0;
            port_q  <= '0;
            rr_port <= '0;
            way_q   <= '0;
            hit_q   <= 1'b0;
            line_q  <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    vld[w][s] <= 1'b0;
                end
            end
            for (int s = 0; s < SETS; s++) begin
                vic_ptr[s] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (inv_req) begin
                        op_q  <= OP_INV;
                        blk_q <= inv_addr;
                        state <= S_LOOKUP;
                    end else if (wr_req) begin
                        op_q   <= OP_WR;
                        blk_q  <= wr_addr[ADDR_W-1:OFF_W];
                        off_q  <= wr_off;
                        len_q  <= wr_len;
                        wdat_q <= wr_data;
                        state  <= S_LOOKUP;
                    end else if (rd_any) begin
                        op_q    <= OP_RD;
                        blk_q   <= rd_blk;
                        port_q  <= rd_gnt;
                        rr_port <= (rd_gnt == PW'(NRD - 1)) ? '0 : rd_gnt + 1'b1;
                        state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    way_q <= hit_way;
                    hit_q <= hit;
                    case (op_q)
                        OP_INV:  state <= S_INVAL;
                        OP_WR:   state <= hit ? S_WRITE : S_FETCH;
                        default: begin
                            if (hit) begin
                                line_q <= data_mem[hit_way][idx];
                                state  <= S_RESP;
                            end else begin
                                state <= S_FETCH;
                            end
                        end
                    endcase
                end
                S_FETCH: begin
                    if (ext_dv) begin
                        line_q <= ext_data;
                        state  <= S_FILL;
                    end
                end
                S_FILL: begin
                    vld[vic_way][idx] <= 1'b1;
                    vic_ptr[idx]      <= vic_next;
                    way_q             <= vic_way;
                    state             <= (op_q == OP_WR) ? S_WRITE : S_RESP;
                end
                S_INVAL: begin
                    if (hit_q) begin
                        vld[way_q][idx] <= 1'b0;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Line and tag storage: fills install fetched lines, stores merge into the target way
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == S_FILL) begin
                data_mem[vic_way][idx] <= line_q;
                tag_mem[vic_way][idx]  <= tag;
            end else if (state == S_WRITE) begin
                data_mem[way_q][idx] <= merged;
            end
        end
    end

    assign rd_data  = line_q;
    assign rd_dv    = (state == S_RESP) ? (NRD'(1) << port_q) : '0;
    assign wr_ack   = (state == S_WRITE);
    assign inv_ack  = (state == S_INVAL);
    assign ext_rd   = (state == S_FETCH);
    assign ext_addr = ext_rd ? blk_q : '0;

endmodule

// File: tb/tb_cmem_nway.sv
// tb/tb_cmem_nway.sv - randomized self-checking bench for cmem_nway against a behavioural cache model
module tb_cmem_nway;
    localparam int WAYS   = 2;
    localparam int SETS   = 4;
    localparam int LINE_W = 128;
    localparam int NRD    = 2;
    localparam int ADDR_W = 64;
    localparam int BLK_W  = 60;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NRD-1:0]       rd_req = '0;
    logic [NRD*BLK_W-1:0] rd_addr = '0;
    logic [LINE_W-1:0]    rd_data;
    logic [NRD-1:0]       rd_dv;
    logic                 wr_req = 1'b0;
    logic [ADDR_W-1:0]    wr_addr = '0;
    logic [63:0]          wr_data = '0;
    logic [1:0]           wr_len = '0;
    logic                 wr_ack;
    logic                 inv_req = 1'b0;
    logic [BLK_W-1:0]     inv_addr = '0;
    logic                 inv_ack;
    logic                 ext_rd;
    logic [BLK_W-1:0]     ext_addr;
    logic [LINE_W-1:0]    ext_data = '0;
    logic                 ext_dv = 1'b0;

    always #5 clk = ~clk;

    cmem_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_W(LINE_W), .NRD(NRD), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_dv(rd_dv),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_len(wr_len), .wr_ack(wr_ack),
        .inv_req(inv_req), .inv_addr(inv_addr), .inv_ack(inv_ack),
        .ext_rd(ext_rd), .ext_addr(ext_addr), .ext_data(ext_data), .ext_dv(ext_dv)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: resident lines per set/way, victim pointers, read-port pointer
    bit                m_val  [WAYS][SETS];
    logic [BLK_W-1:0]  m_blk  [WAYS][SETS];
    logic [LINE_W-1:0] m_line [WAYS][SETS];
    int                m_rr   [SETS];
    int                m_ptr;

    function automatic logic [LINE_W-1:0] pattern(input logic [BLK_W-1:0] b);
        logic [31:0] x;
        x = b[31:0];
        return {x ^ 32'hA5C3_0F1E, x * 32'h0100_0193, ~x, x + 32'h5A5A_0000};
    endfunction

    task automatic model_reset();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) m_val[w][s] = 1'b0;
        for (int s = 0; s < SETS; s++) m_rr[s] = 0;
        m_ptr = 0;
    endtask

    function automatic int m_find(input logic [BLK_W-1:0] b);
        int s;
        s = int'(b % SETS);
        for (int w = 0; w < WAYS; w++)
            if (m_val[w][s] && m_blk[w][s] == b) return w;
        return -1;
    endfunction

    function automatic int m_fill(input logic [BLK_W-1:0] b);
        int s;
        int v;
        s = int'(b % SETS);
        v = -1;
        for (int w = 0; w < WAYS; w++)
            if (v < 0 && !m_val[w][s]) v = w;
        if (v < 0) v = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % WAYS;
        m_val[v][s]  = 1'b1;
        m_blk[v][s]  = b;
        m_line[v][s] = pattern(b);
        return v;
    endfunction

    typedef struct {
        int                kind;
        int                port;
        logic [LINE_W-1:0] data;
        bit                fetched;
        logic [BLK_W-1:0]  fblk;
        int                lat;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    bit                b_rd   [NRD];
    logic [BLK_W-1:0]  b_rblk [NRD];
    bit                b_wr;
    logic [63:0]       b_waddr;
    logic [63:0]       b_wdata;
    logic [1:0]        b_wlen;
    bit                b_inv;
    logic [BLK_W-1:0]  b_iblk;

    task automatic clear_batch();
        for (int p = 0; p < NRD; p++) begin
            b_rd[p] = 1'b0;
            b_rblk[p] = '0;
        end
        b_wr = 1'b0; b_waddr = '0; b_wdata = '0; b_wlen = '0;
        b_inv = 1'b0; b_iblk = '0;
    endtask

    // Serve the pending set in priority order: invalidate, store, then reads in rotation
    task automatic build_expected();
        bit prd [NRD];
        bit pwr;
        bit pinv;
        ev_t e;
        int w;
        int s;
        int p;
        int off;
        logic [BLK_W-1:0] b;
        prd = b_rd;
        pwr = b_wr;
        pinv = b_inv;
        exp_q.delete();
        for (int step = 0; step < NRD + 2; step++) begin
            e.kind = 0; e.port = 0; e.data = '0; e.fetched = 1'b0; e.fblk = '0; e.lat = 0;
            if (pinv) begin
                pinv = 1'b0;
                e.kind = 2;
                w = m_find(b_iblk);
                if (w >= 0) m_val[w][int'(b_iblk % SETS)] = 1'b0;
                exp_q.push_back(e);
            end else if (pwr) begin
                pwr = 1'b0;
                e.kind = 1;
                b = b_waddr[63:4];
                s = int'(b % SETS);
                w = m_find(b);
                if (w < 0) begin
                    e.fetched = 1'b1;
                    e.fblk = b;
                    w = m_fill(b);
                end
                off = int'(b_waddr[3:0]) & ~((1 << b_wlen) - 1);
                for (int k = 0; k < (1 << b_wlen); k++)
                    m_line[w][s][8*(off+k) +: 8] = b_wdata[8*k +: 8];
                exp_q.push_back(e);
            end else begin
                p = -1;
                for (int i = 0; i < NRD; i++)
                    if (p < 0 && prd[(m_ptr + i) % NRD]) p = (m_ptr + i) % NRD;
                if (p >= 0) begin
                    prd[p] = 1'b0;
                    m_ptr = (p + 1) % NRD;
                    b = b_rblk[p];
                    s = int'(b % SETS);
                    w = m_find(b);
                    if (w < 0) begin
                        e.fetched = 1'b1;
                        e.fblk = b;
                        w = m_fill(b);
                    end
                    e.kind = 0;
                    e.port = p;
                    e.data = m_line[w][s];
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Present the batch, act as external memory, record completions, then compare to the model
    task automatic run_batch(input int budget);
        int  cyc;
        bit  fseen;
        logic [BLK_W-1:0] fblk;
        int  dly;
        int  n;
        ev_t e;
        cyc = 0; fseen = 1'b0; fblk = '0; dly = 0;
        build_expected();
        obs_q.delete();
        for (int p = 0; p < NRD; p++) begin
            rd_req[p] = b_rd[p];
            rd_addr[p*BLK_W +: BLK_W] = b_rblk[p];
        end
        wr_req = b_wr; wr_addr = b_waddr; wr_data = b_wdata; wr_len = b_wlen;
        inv_req = b_inv; inv_addr = b_iblk;
        while ((rd_req != 0 || wr_req || inv_req) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            ext_dv = 1'b0;
            if (ext_rd) begin
                if (!fseen) begin
                    fseen = 1'b1;
                    fblk = ext_addr;
                    dly = $urandom_range(0, 3);
                end
                if (dly == 0) begin
                    ext_dv = 1'b1;
                    ext_data = pattern(ext_addr);
                end else begin
                    dly--;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                ext_dv = 1'b1;
                ext_data = {$urandom, $urandom, $urandom, $urandom};
            end
            n = $countones({rd_dv, wr_ack, inv_ack});
            if (n != 0) check("ack_exclusive", (n <= 1), 1);
            if (n != 0) begin
                e.port = 0; e.data = '0; e.fetched = fseen; e.fblk = fblk; e.lat = cyc;
                if (rd_dv != 0) begin
                    check("rd_dv_onehot", $onehot(rd_dv), 1);
                    e.kind = 0;
                    for (int p = 0; p < NRD; p++) if (rd_dv[p]) e.port = p;
                    e.data = rd_data;
                    rd_req = rd_req & ~rd_dv;
                end else if (wr_ack) begin
                    e.kind = 1;
                    wr_req = 1'b0;
                end else begin
                    e.kind = 2;
                    inv_req = 1'b0;
                end
                obs_q.push_back(e);
                fseen = 1'b0;
            end
        end
        if (rd_req != 0 || wr_req || inv_req) check("batch_timeout", 1, 0);
        rd_req = '0; wr_req = 1'b0; inv_req = 1'b0;
        @(negedge clk);
        ext_dv = 1'b0;
        check("event_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check("ev_kind", obs_q[i].kind, exp_q[i].kind);
            check("ev_fetched", obs_q[i].fetched, exp_q[i].fetched);
            if (exp_q[i].fetched) check("ev_fetch_addr", obs_q[i].fblk, exp_q[i].fblk);
            if (exp_q[i].kind == 0) begin
                check("ev_port", obs_q[i].port, exp_q[i].port);
                check("ev_rd_data", obs_q[i].data, exp_q[i].data);
            end
        end
    endtask

    task automatic rd1(input int p, input logic [BLK_W-1:0] b);
        clear_batch();
        b_rd[p] = 1'b1;
        b_rblk[p] = b;
        run_batch(200);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rd_req = '0; wr_req = 1'b0; inv_req = 1'b0; ext_dv = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    logic [LINE_W-1:0] msk;
    int  waited;
    bit  seen;

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_dv", rd_dv, 0);
        check("rst_wr_ack", wr_ack, 0);
        check("rst_inv_ack", inv_ack, 0);
        check("rst_ext_rd", ext_rd, 0);
        check("rst_ext_addr", ext_addr, 0);
        check("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss then hit on port 0
        rd1(0, 60'h10);
        check("miss_fetched", obs_q[0].fetched, 1);
        check("miss_ext_addr", obs_q[0].fblk, 60'h10);
        check("miss_data", obs_q[0].data, pattern(60'h10));
        rd1(0, 60'h10);
        check("hit_no_fetch", obs_q[0].fetched, 0);
        check("hit_latency", obs_q[0].lat, 2);

        // Simultaneous hits: rotation decides which port goes first
        rd1(1, 60'h10);
        clear_batch();
        b_rd[0] = 1'b1; b_rblk[0] = 60'h10;
        b_rd[1] = 1'b1; b_rblk[1] = 60'h10;
        run_batch(200);
        check("pair1_first", obs_q[0].port, 0);
        check("pair1_second", obs_q[1].port, 1);
        rd1(0, 60'h10);
        clear_batch();
        b_rd[0] = 1'b1; b_rblk[0] = 60'h10;
        b_rd[1] = 1'b1; b_rblk[1] = 60'h10;
        run_batch(200);
        check("pair2_first", obs_q[0].port, 1);

        // Byte store into a resident line, then read back
        clear_batch();
        b_wr = 1'b1; b_waddr = 64'h103; b_wdata = 64'hFFFF_FFFF_FFFF_FFA5; b_wlen = 2'd0;
        run_batch(200);
        check("store_ack", obs_q[0].kind, 1);
        rd1(0, 60'h10);
        check("store_byte3", obs_q[0].data[31:24], 8'hA5);
        msk = ~(128'hFF << 24);
        check("store_others", obs_q[0].data & msk, pattern(60'h10) & msk);

        // Three fills in one set: third evicts way 0
        do_reset();
        rd1(0, 60'h00);
        rd1(0, 60'h04);
        rd1(0, 60'h08);
        rd1(0, 60'h04);
        check("evict_keep_way1", obs_q[0].fetched, 0);
        rd1(0, 60'h00);
        check("evict_way0_miss", obs_q[0].fetched, 1);

        // Invalidate beats a simultaneous store
        clear_batch();
        b_inv = 1'b1; b_iblk = 60'h08;
        b_wr = 1'b1; b_waddr = 64'h45; b_wdata = {$urandom, $urandom}; b_wlen = 2'd1;
        run_batch(200);
        check("inv_first", obs_q[0].kind, 2);
        check("wr_second", obs_q[1].kind, 1);
        rd1(1, 60'h08);
        check("inv_then_miss", obs_q[0].fetched, 1);

        // Reset in the middle of a fetch, late ext_dv afterwards
        rd_req[0] = 1'b1;
        rd_addr[0 +: BLK_W] = 60'h3C;
        waited = 0;
        while (!ext_rd && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("midfetch_ext_rd", ext_rd, 1);
        check("midfetch_ext_addr", ext_addr, 60'h3C);
        rst_n = 1'b0;
        rd_req = '0;
        @(negedge clk);
        check("rst_drops_ext_rd", ext_rd, 0);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        ext_dv = 1'b1;
        ext_data = pattern(60'h3C);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ext_dv = 1'b0;
            if (rd_dv != 0) seen = 1'b1;
        end
        check("late_dv_no_rd_dv", seen, 0);
        check("late_dv_ext_rd", ext_rd, 0);
        rd1(0, 60'h10);
        check("post_rst_miss_a", obs_q[0].fetched, 1);
        rd1(1, 60'h04);
        check("post_rst_miss_b", obs_q[0].fetched, 1);

        // Randomized mixed traffic against the model
        for (int t = 0; t < 150; t++) begin
            clear_batch();
            for (int p = 0; p < NRD; p++) begin
                b_rd[p] = ($urandom_range(0, 1) == 1);
                b_rblk[p] = 60'($urandom_range(0, 11));
            end
            b_wr = ($urandom_range(0, 2) == 0);
            b_waddr = 64'($urandom_range(0, 11)) * 16 + 64'($urandom_range(0, 15));
            b_wdata = {$urandom, $urandom};
            b_wlen = 2'($urandom_range(0, 3));
            b_inv = ($urandom_range(0, 4) == 0);
            b_iblk = 60'($urandom_range(0, 11));
            if (!b_rd[0] && !b_rd[1] && !b_wr && !b_inv) b_rd[0] = 1'b1;
            run_batch(400);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
